// File: rtl/dct_mult_batch_sched.sv
// Ping-pong batch scheduler: gathers four 4-lane product beats into a 16-word
// block per bank and streams each full block out one word per cycle.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_EMPTY    | bank holds no data, writable
//   S_FILLING  | some beats of the block written, writable
//   S_FULL     | all beats written, waiting for word 0 to reach dout
//   S_DRAINING | words being loaded to dout, freed at word 15 handshake
module dct_mult_batch_sched #(
   parameter int DATA_W  = 36,
   parameter int LANES   = 4,
   parameter int BATCHES = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] din2,
   input  logic [DATA_W-1:0] din3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] dout,
   output logic [3:0]        out_idx,
   output logic              out_last,
   output logic [1:0]        bank_full,
   output logic [CNT_W-1:0]  blk_cnt
);

   localparam int DEPTH   = LANES * BATCHES;
   localparam int BATCH_W = 2;
   localparam int LANE_W  = 2;
   localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(BATCHES - 1);
   localparam logic [3:0]         LAST_IDX   = 4'(DEPTH - 1);

   localparam logic [1:0] S_EMPTY    = 2'd0;
   localparam logic [1:0] S_FILLING  = 2'd1;
   localparam logic [1:0] S_FULL     = 2'd2;
   localparam logic [1:0] S_DRAINING = 2'd3;

   logic [1:0]         bank_st [2];
   logic               wr_bank;
   logic [BATCH_W-1:0] wr_batch;
   logic               rd_bank;
   logic [3:0]         rd_idx;
   logic               out_bank;
   logic [DATA_W-1:0]  mem [2*DEPTH];
   logic [DATA_W-1:0]  din_lane [LANES];

   logic accept;
   logic wr_last;
   logic readable;
   logic adv;
   logic load;
   logic blk_done;

   assign din_lane[0] = din0;
   assign din_lane[1] = din1;
   assign din_lane[2] = din2;
   assign din_lane[3] = din3;

   assign in_ready = !rst && (bank_st[wr_bank] == S_EMPTY || bank_st[wr_bank] == S_FILLING);
   assign accept   = in_valid && in_ready;
   assign wr_last  = (wr_batch == LAST_BATCH);
   assign readable = (bank_st[rd_bank] == S_FULL) || (bank_st[rd_bank] == S_DRAINING);
   assign adv      = !out_valid || out_ready;
   assign load     = adv && readable;
   assign blk_done = out_valid && out_ready && out_last;

   // FULL and DRAINING share the upper state bit
   assign bank_full = {bank_st[1][1], bank_st[0][1]};

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int l = 0; l < LANES; l++) begin
            mem[{wr_bank, wr_batch, LANE_W'(l)}] <= din_lane[l];
         end
      end
   end

   // write, first load and release never target the same bank in one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_st[0] <= S_EMPTY;
         bank_st[1] <= S_EMPTY;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (accept && wr_bank == 1'(b)) begin
               bank_st[b] <= wr_last ? S_FULL : S_FILLING;
            end else if (load && rd_bank == 1'(b) && rd_idx == 4'd0) begin
               bank_st[b] <= S_DRAINING;
            end else if (blk_done && out_bank == 1'(b)) begin
               bank_st[b] <= S_EMPTY;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank  <= 1'b0;
         wr_batch <= '0;
      end else if (accept) begin
         wr_batch <= wr_last ? '0 : wr_batch + 1'b1;
         if (wr_last) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_bank   <= 1'b0;
         rd_idx    <= 4'd0;
         out_bank  <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         out_idx   <= 4'd0;
         out_last  <= 1'b0;
         blk_cnt   <= '0;
      end else begin
         if (load) begin
            dout      <= mem[{rd_bank, rd_idx}];
            out_idx   <= rd_idx;
            out_last  <= (rd_idx == LAST_IDX);
            out_valid <= 1'b1;
            out_bank  <= rd_bank;
            rd_idx    <= rd_idx + 4'd1;
            if (rd_idx == LAST_IDX) begin
               rd_bank <= ~rd_bank;
            end
         end else if (adv) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (blk_done) begin
            blk_cnt <= blk_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dct_mult_batch_sched.sv
// Bench for dct_mult_batch_sched: directed scenarios plus randomized traffic
// checked against an in-order word queue and block-count arithmetic.
module tb_dct_mult_batch_sched;

   localparam int DW = 36;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;

   logic          in_ready, out_valid, out_last;
   logic [DW-1:0] dout;
   logic [3:0]    out_idx;
   logic [1:0]    bank_full;
   logic [15:0]   blk_cnt;

   logic          w_in_ready, w_out_valid, w_out_last;
   logic [DW-1:0] w_dout;
   logic [3:0]    w_out_idx;
   logic [1:0]    w_bank_full;
   logic [1:0]    w_blk_cnt;

   dct_mult_batch_sched #(.DATA_W(DW), .LANES(4), .BATCHES(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din0(din0), .din1(din1), .din2(din2), .din3(din3),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_idx(out_idx),
      .out_last(out_last), .bank_full(bank_full), .blk_cnt(blk_cnt));

   dct_mult_batch_sched #(.DATA_W(DW), .LANES(4), .BATCHES(4), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .din0(din0), .din1(din1), .din2(din2), .din3(din3),
      .out_valid(w_out_valid), .out_ready(out_ready), .dout(w_dout), .out_idx(w_out_idx),
      .out_last(w_out_last), .bank_full(w_bank_full), .blk_cnt(w_blk_cnt));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: words leave in the order they were accepted; a bank is
   // held by every complete block not yet fully handshaked.
   logic [DW-1:0] exp_q [$];
   int acc  = 0;
   int ocnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc  = 0;
         ocnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            ocnt++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(din0);
            exp_q.push_back(din1);
            exp_q.push_back(din2);
            exp_q.push_back(din3);
            acc++;
         end
      end
   end

   function automatic logic model_in_ready();
      return (acc % 4 != 0) || ((acc / 4 - ocnt / 16) < 2);
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      return DW'({$urandom(), $urandom()});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d);
      in_valid = 1'b1;
      din0 = a; din1 = b; din2 = c; din3 = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) cyc();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
      n_checks++; if (out_idx !== 4'd0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_idx_last got %0d/%b want 0/0", out_idx, out_last); end
      n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL reset_bank_full got %b want 00", bank_full); end
      n_checks++; if (blk_cnt !== 16'd0 || w_blk_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_blk_cnt got %0d/%0d want 0/0", blk_cnt, w_blk_cnt); end
      rst = 1'b0;
      cyc();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_single_block();
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_beat(DW'(4*b), DW'(4*b+1), DW'(4*b+2), DW'(4*b+3));
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready beat %0d got %b want 1", b, in_ready); end
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early got out_valid %b want 0", out_valid); end
      cyc();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || dout !== DW'(i) || out_idx !== 4'(i) || out_last !== (i == 15)) begin
            n_fail++;
            $display("FAIL single_word %0d got v%b d%0d idx%0d last%b want v1 d%0d idx%0d last%b", i, out_valid, dout, out_idx, out_last, i, i, (i == 15));
         end
         cyc();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid got %b want 0", out_valid); end
      n_checks++; if (blk_cnt !== 16'd1 || bank_full !== 2'b00) begin n_fail++; $display("FAIL single_end got blk_cnt %0d bank_full %b want 1 00", blk_cnt, bank_full); end
   endtask

   task automatic test_backpressure();
      int got = 0;
      int c = 0;
      logic hs, prev_stall;
      logic [DW-1:0] prev_d;
      logic [3:0] prev_i;
      prev_stall = 1'b0; prev_d = '0; prev_i = '0;
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         set_beat(DW'(4*b), DW'(4*b+1), DW'(4*b+2), DW'(4*b+3));
         cyc();
      end
      in_valid = 1'b0;
      while (got < 16 && c < 200) begin
         out_ready = (c % 3 == 0);
         if (out_valid) begin
            n_checks++;
            if (dout !== DW'(got) || out_idx !== 4'(got) || out_last !== (got == 15)) begin
               n_fail++;
               $display("FAIL bp_word got d%0d idx%0d last%b want d%0d idx%0d last%b", dout, out_idx, out_last, got, got, (got == 15));
            end
            if (prev_stall) begin
               n_checks++;
               if (dout !== prev_d || out_idx !== prev_i) begin
                  n_fail++;
                  $display("FAIL bp_stable got d%0d idx%0d want d%0d idx%0d", dout, out_idx, prev_d, prev_i);
               end
            end
         end
         hs = out_valid && out_ready;
         prev_stall = out_valid && !out_ready;
         prev_d = dout; prev_i = out_idx;
         cyc();
         if (hs) got++;
         c++;
      end
      n_checks++; if (got != 16) begin n_fail++; $display("FAIL bp_timeout got %0d words want 16", got); end
      n_checks++; if (out_valid !== 1'b0 || blk_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_end got v%b blk_cnt %0d want v0 2", out_valid, blk_cnt); end
   endtask

   task automatic test_ping_pong();
      int beat = 0;
      int got = 0;
      int c = 0;
      logic started, acc_now, hs;
      started = 1'b0;
      out_ready = 1'b1;
      set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      while (got < 48 && c < 300) begin
         n_checks++; if (in_ready !== model_in_ready()) begin n_fail++; $display("FAIL pp_in_ready cycle %0d got %b want %b", c, in_ready, model_in_ready()); end
         if (out_valid) begin
            started = 1'b1;
            n_checks++;
            if (exp_q.size() == 0 || dout !== exp_q[0] || out_idx !== 4'(ocnt % 16)) begin
               n_fail++;
               $display("FAIL pp_word %0d got d%h idx%0d want d%h idx%0d", got, dout, out_idx, (exp_q.size() > 0) ? exp_q[0] : '0, ocnt % 16);
            end
         end else if (started) begin
            n_checks++; n_fail++;
            $display("FAIL pp_bubble after word %0d got out_valid 0 want 1", got);
         end
         acc_now = in_valid && in_ready;
         hs = out_valid && out_ready;
         cyc();
         if (acc_now) begin
            beat++;
            if (beat < 12) set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
            else in_valid = 1'b0;
         end
         if (hs) got++;
         c++;
      end
      n_checks++; if (got != 48) begin n_fail++; $display("FAIL pp_timeout got %0d words want 48", got); end
      n_checks++; if (blk_cnt !== 16'd5 || w_blk_cnt !== 2'd1) begin n_fail++; $display("FAIL pp_blk_cnt got %0d/%0d want 5/1", blk_cnt, w_blk_cnt); end
   endtask

   task automatic test_both_full();
      int hs_cnt = 0;
      int c = 0;
      logic hs, acc_now;
      out_ready = 1'b0;
      for (int b = 0; b < 8; b++) begin
         set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready beat %0d got %b want 1", b, in_ready); end
         cyc();
      end
      set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      n_checks++; if (in_ready !== 1'b0 || bank_full !== 2'b11) begin n_fail++; $display("FAIL full_blocked got in_ready %b bank_full %b want 0 11", in_ready, bank_full); end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++; if (in_ready !== 1'b0 || bank_full !== 2'b11) begin n_fail++; $display("FAIL full_hold %0d got in_ready %b bank_full %b want 0 11", i, in_ready, bank_full); end
      end
      out_ready = 1'b1;
      while (hs_cnt < 32 && c < 100) begin
         n_checks++; if (in_ready !== (hs_cnt >= 16)) begin n_fail++; $display("FAIL full_release after %0d words got in_ready %b want %b", hs_cnt, in_ready, (hs_cnt >= 16)); end
         if (out_valid) begin
            n_checks++;
            if (exp_q.size() == 0 || dout !== exp_q[0]) begin
               n_fail++;
               $display("FAIL full_word %0d got %h want %h", hs_cnt, dout, (exp_q.size() > 0) ? exp_q[0] : '0);
            end
         end
         hs = out_valid && out_ready;
         acc_now = in_valid && in_ready;
         cyc();
         if (acc_now) in_valid = 1'b0;
         if (hs) hs_cnt++;
         c++;
      end
      n_checks++; if (hs_cnt != 32 || blk_cnt !== 16'd7) begin n_fail++; $display("FAIL full_end got %0d words blk_cnt %0d want 32 7", hs_cnt, blk_cnt); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cyc();
      rst = 1'b0;
      for (int b = 0; b < 4; b++) begin
         set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
         cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 2) set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
         else in_valid = 1'b0;
         cyc();
      end
      rst = 1'b1;
      set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      cyc();
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout !== '0) begin n_fail++; $display("FAIL midrst_out got in_ready %b v%b d%h want 0 0 0", in_ready, out_valid, dout); end
      n_checks++; if (out_idx !== 4'd0 || out_last !== 1'b0 || bank_full !== 2'b00 || blk_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_state got idx%0d last%b full%b cnt%0d want 0 0 00 0", out_idx, out_last, bank_full, blk_cnt); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", in_ready); end
      for (int b = 0; b < 4; b++) begin
         set_beat(DW'(100+4*b), DW'(101+4*b), DW'(102+4*b), DW'(103+4*b));
         cyc();
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale beat %0d got out_valid %b want 0", b, out_valid); end
      end
      in_valid = 1'b0;
      cyc();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || dout !== DW'(100+i) || out_idx !== 4'(i)) begin
            n_fail++;
            $display("FAIL midrst_word %0d got v%b d%0d idx%0d want v1 d%0d idx%0d", i, out_valid, dout, out_idx, 100+i, i);
         end
         cyc();
      end
      n_checks++; if (blk_cnt !== 16'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_end got cnt%0d v%b want 1 0", blk_cnt, out_valid); end
   endtask

   task automatic test_random();
      logic acc_now, exp_ir, exp_last;
      logic [3:0] exp_idx;
      int nfull;
      for (int c = 0; c < 800; c++) begin
         if (!in_valid && ($urandom % 4 != 0)) set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
         out_ready = ((c / 100) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
         exp_ir = model_in_ready();
         nfull = acc / 4 - ocnt / 16;
         exp_idx = 4'(ocnt % 16);
         exp_last = (ocnt % 16 == 15);
         n_checks++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", c, in_ready, exp_ir); end
         n_checks++; if ($countones(bank_full) != nfull) begin n_fail++; $display("FAIL rnd_bank_full cycle %0d got %b want %0d full", c, bank_full, nfull); end
         n_checks++; if (blk_cnt !== 16'(ocnt / 16) || w_blk_cnt !== 2'(ocnt / 16)) begin n_fail++; $display("FAIL rnd_blk_cnt cycle %0d got %0d/%0d want %0d", c, blk_cnt, w_blk_cnt, ocnt / 16); end
         if (out_valid) begin
            n_checks++;
            if (exp_q.size() == 0 || dout !== exp_q[0] || out_idx !== exp_idx || out_last !== exp_last) begin
               n_fail++;
               $display("FAIL rnd_word cycle %0d got d%h idx%0d last%b want d%h idx%0d last%b", c, dout, out_idx, out_last, (exp_q.size() > 0) ? exp_q[0] : '0, exp_idx, exp_last);
            end
         end
         n_checks++;
         if (w_in_ready !== exp_ir || $countones(w_bank_full) != nfull ||
             (w_out_valid && (exp_q.size() == 0 || w_dout !== exp_q[0] || w_out_idx !== exp_idx || w_out_last !== exp_last))) begin
            n_fail++;
            $display("FAIL rnd_wrap_inst cycle %0d got ir%b full%b v%b idx%0d want ir%b %0d full idx%0d", c, w_in_ready, w_bank_full, w_out_valid, w_out_idx, exp_ir, nfull, exp_idx);
         end
         acc_now = in_valid && in_ready;
         cyc();
         if (acc_now) in_valid = 1'b0;
      end
   endtask

   task automatic test_cnt_wrap();
      logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic hs_last, seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      rst = 1'b0;
      for (int blk = 0; blk < 5; blk++) begin
         for (int b = 0; b < 4; b++) begin
            set_beat(rnd_word(), rnd_word(), rnd_word(), rnd_word());
            cyc();
         end
         in_valid = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 40 && !seen; c++) begin
            hs_last = out_valid && out_ready && out_last;
            cyc();
            seen = hs_last;
         end
         n_checks++;
         if (!seen || w_blk_cnt !== seq[blk] || blk_cnt !== 16'(blk + 1)) begin
            n_fail++;
            $display("FAIL wrap_blk %0d got done%b cnt2 %0d cnt16 %0d want 1 %0d %0d", blk, seen, w_blk_cnt, blk_cnt, seq[blk], blk + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_backpressure();
      test_ping_pong();
      test_both_full();
      test_reset_mid();
      test_random();
      test_cnt_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
